mix_one_column: RTL and testbench

MIX_ONE_COLUMN -- requirements
Module: mix_one_column

---
 rtl/mix_col_pkg.sv | 40 ++++
 rtl/gf_xtime.sv | 17 +
 rtl/mix_one_column.sv | 109 ++++++++++
 tb/tb_mix_one_column.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mix_col_pkg.sv
// Shared types and GF(2^8) helpers for the AES column-mix datapath.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   byte_t       : one GF(2^8) element
//   column_t     : four bytes, [0] = row 0 in bits 7:0, [3] = row 3 in bits 31:24
//   AES_POLY_LOW : low byte of the reduction polynomial x^8+x^4+x^3+x+1 (0x11B)
//   xtime()      : multiply by x (i.e. by 0x02) with modular reduction
//   gmul()       : general GF(2^8) multiply, built from repeated xtime
package mix_col_pkg;

  typedef logic [7:0]      byte_t;
  typedef logic [3:0][7:0] column_t;

  // The x^8 term is implicit: it is what falls out of bit 7 on the shift.
  localparam byte_t AES_POLY_LOW = 8'h1B;

  function automatic byte_t xtime(input byte_t a);
    byte_t shifted;
    shifted = {a[6:0], 1'b0};
    return a[7] ? (shifted ^ AES_POLY_LOW) : shifted;
  endfunction

  // Shift-and-add multiply: accumulate a*x^i for every set bit i of b.
  function automatic byte_t gmul(input byte_t a, input byte_t b);
    byte_t acc;
    byte_t pwr;
    acc = 8'h00;
    pwr = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ pwr;
      end
      pwr = xtime(pwr);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf_xtime.sv
// GF(2^8) doubling (multiply by 0x02 modulo 0x11B) for a single byte.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
//
// Ports:
//   a : input byte
//   y : a * 0x02 in GF(2^8)
module gf_xtime
  import mix_col_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = xtime(a);

endmodule

// File: rtl/mix_one_column.sv
// AES MixColumns on one 32-bit column, result registered once.
// Latency: 1 cycle from an accepting edge to out/out_valid.
// Backpressure: none; one column accepted every cycle in_valid is high.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   in_valid   : column on `in` is presented this cycle
//   in         : column bytes, in[0] = row 0 (bits 7:0) .. in[3] = row 3
//   inv        : 1 = InvMixColumns, 0 = MixColumns (only with MIX_ONE_COLUMN_INV_EN)
//   out_valid  : out holds the result for the column accepted last cycle
//   out        : transformed column, same byte/row ordering as `in`
//
// Build option: define MIX_ONE_COLUMN_INV_EN to add the `inv` port and the
// inverse datapath; otherwise only the forward transform is built.
module mix_one_column
  import mix_col_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0][7:0]  in,
`ifdef MIX_ONE_COLUMN_INV_EN
  input  logic             inv,
`endif
  output logic             out_valid,
  output logic [3:0][7:0]  out
);

  column_t col_in;
  column_t fwd_col;
  column_t next_col;

  byte_t   x2 [4];   // a*02
  byte_t   x3 [4];   // a*03

  assign col_in = in;

  // Per-byte multiples shared by every output row that needs them.
  for (genvar g = 0; g < 4; g++) begin : g_fwd_mult
    gf_xtime u_x2 (
      .a (col_in[g]),
      .y (x2[g])
    );
    assign x3[g] = x2[g] ^ col_in[g];
  end

  // Row r combines byte r..r+3 (mod 4) with coefficients 02,03,01,01.
  for (genvar r = 0; r < 4; r++) begin : g_fwd_row
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;
    assign fwd_col[r] = x2[r] ^ x3[R1] ^ col_in[R2] ^ col_in[R3];
  end

`ifdef MIX_ONE_COLUMN_INV_EN
  column_t inv_col;

  byte_t   x4 [4];   // a*04
  byte_t   x8 [4];   // a*08
  byte_t   x9 [4];   // a*09 = 08+01
  byte_t   xb [4];   // a*0b = 08+02+01
  byte_t   xd [4];   // a*0d = 08+04+01
  byte_t   xe [4];   // a*0e = 08+04+02

  // The x4/x8 chain reuses the forward doubling, so the inverse only adds
  // two more xtime stages per byte plus XORs.
  for (genvar g = 0; g < 4; g++) begin : g_inv_mult
    gf_xtime u_x4 (
      .a (x2[g]),
      .y (x4[g])
    );
    gf_xtime u_x8 (
      .a (x4[g]),
      .y (x8[g])
    );
    assign x9[g] = x8[g] ^ col_in[g];
    assign xb[g] = x8[g] ^ x2[g] ^ col_in[g];
    assign xd[g] = x8[g] ^ x4[g] ^ col_in[g];
    assign xe[g] = x8[g] ^ x4[g] ^ x2[g];
  end

  // Same rotation as forward, coefficients 0e,0b,0d,09.
  for (genvar r = 0; r < 4; r++) begin : g_inv_row
    localparam int R1 = (r + 1) % 4;
    localparam int R2 = (r + 2) % 4;
    localparam int R3 = (r + 3) % 4;
    assign inv_col[r] = xe[r] ^ xb[R1] ^ xd[R2] ^ x9[R3];
  end

  // inv travels with the column, so the select is taken on the same edge.
  assign next_col = inv ? inv_col : fwd_col;
`else
  assign next_col = fwd_col;
`endif

  // Output register: loads only on accepted columns, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= next_col;
      end
    end
  end

endmodule

// File: tb/tb_mix_one_column.sv
// Self-checking bench for mix_one_column: directed vectors, hold/back-to-back,
// asynchronous reset, and randomized columns against a matrix-product model.
// Inverse cases are exercised when MIX_ONE_COLUMN_INV_EN is defined.
module tb_mix_one_column;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [3:0][7:0] in_col;
  logic            inv_sel;
  logic            out_valid;
  logic [3:0][7:0] out_col;

  int total;
  int bad;

  logic [31:0] exp_out;
  logic        exp_vld;

  mix_one_column dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in        (in_col),
`ifdef MIX_ONE_COLUMN_INV_EN
    .inv       (inv_sel),
`endif
    .out_valid (out_valid),
    .out       (out_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    if (obs !== req) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, req);
    end
  endtask

  // Build a column from row bytes listed row 0 first.
  function automatic logic [31:0] col4(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  // Carry-less polynomial product, then long-division reduction by 0x11B.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ (15'(a) << i);
    end
    for (int k = 14; k >= 8; k--) begin
      if (p[k]) p = p ^ (15'h11B << (k - 8));
    end
    return p[7:0];
  endfunction

  // Circulant matrix times column: row r uses coef[k] on byte (r+k) mod 4.
  function automatic logic [31:0] model(input logic [31:0] c, input logic iv);
    logic [7:0] coef [4];
    logic [7:0] a [4];
    logic [7:0] o [4];
    if (iv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int i = 0; i < 4; i++) a[i] = c[8*i +: 8];
    for (int r = 0; r < 4; r++) begin
      o[r] = 8'h00;
      for (int k = 0; k < 4; k++) o[r] = o[r] ^ gf_mul(coef[k], a[(r + k) % 4]);
    end
    return col4(o[0], o[1], o[2], o[3]);
  endfunction

  // Present one cycle of input, then sample just after the capturing edge
  // and advance the reference.
  task automatic drive(input logic [31:0] c, input logic v, input logic iv);
    @(negedge clk);
    in_col   = c;
    in_valid = v;
    inv_sel  = iv;
    @(posedge clk);
    #1;
    if (v) exp_out = model(c, iv);
    exp_vld = v;
  endtask

  task automatic step(input string tag, input logic [31:0] c, input logic v, input logic iv);
    drive(c, v, iv);
    check({tag, "_vld"}, {31'b0, out_valid}, {31'b0, exp_vld});
    check({tag, "_out"}, out_col, exp_out);
  endtask

  initial begin
    logic [31:0] c;
    logic        v;
    logic        iv;

    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_col   = '0;
    inv_sel  = 1'b0;
    exp_out  = '0;
    exp_vld  = 1'b0;

    #3;
    check("rst_out", out_col, 32'h0);
    check("rst_vld", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed forward vectors, checked against literal results.
    step("d0", col4(8'hdb, 8'h13, 8'h53, 8'h45), 1'b1, 1'b0);
    check("d0_lit", out_col, col4(8'h8e, 8'h4d, 8'ha1, 8'hbc));
    step("d1", col4(8'hf2, 8'h0a, 8'h22, 8'h5c), 1'b1, 1'b0);
    check("d1_lit", out_col, col4(8'h9f, 8'hdc, 8'h58, 8'h9d));
    step("d2", col4(8'hd4, 8'hd4, 8'hd4, 8'hd5), 1'b1, 1'b0);
    check("d2_lit", out_col, col4(8'hd5, 8'hd5, 8'hd7, 8'hd6));
    step("d3", col4(8'h01, 8'h01, 8'h01, 8'h01), 1'b1, 1'b0);
    check("d3_lit", out_col, col4(8'h01, 8'h01, 8'h01, 8'h01));
    step("d4", col4(8'hc6, 8'hc6, 8'hc6, 8'hc6), 1'b1, 1'b0);
    check("d4_lit", out_col, col4(8'hc6, 8'hc6, 8'hc6, 8'hc6));

    // Back-to-back, then an idle cycle must hold the last result.
    step("b0", col4(8'hdb, 8'h13, 8'h53, 8'h45), 1'b1, 1'b0);
    check("b0_lit", out_col, col4(8'h8e, 8'h4d, 8'ha1, 8'hbc));
    step("b1", col4(8'h2d, 8'h26, 8'h31, 8'h4c), 1'b1, 1'b0);
    check("b1_lit", out_col, col4(8'h4d, 8'h7e, 8'hbd, 8'hf8));
    step("hold", 32'hdeadbeef, 1'b0, 1'b0);
    check("hold_vld", {31'b0, out_valid}, 32'h0);
    check("hold_lit", out_col, col4(8'h4d, 8'h7e, 8'hbd, 8'hf8));

`ifdef MIX_ONE_COLUMN_INV_EN
    step("i0", col4(8'h8e, 8'h4d, 8'ha1, 8'hbc), 1'b1, 1'b1);
    check("i0_lit", out_col, col4(8'hdb, 8'h13, 8'h53, 8'h45));
    step("i1", col4(8'h9f, 8'hdc, 8'h58, 8'h9d), 1'b1, 1'b1);
    check("i1_lit", out_col, col4(8'hf2, 8'h0a, 8'h22, 8'h5c));
`endif

    // Reset asserted between edges mid-stream clears outputs immediately.
    step("pre_rst", col4(8'hf2, 8'h0a, 8'h22, 8'h5c), 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", out_col, 32'h0);
    check("arst_vld", {31'b0, out_valid}, 32'h0);
    // A column offered while reset is held is discarded.
    @(negedge clk);
    in_col   = col4(8'hdb, 8'h13, 8'h53, 8'h45);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("inrst_out", out_col, 32'h0);
    check("inrst_vld", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    exp_out  = '0;
    exp_vld  = 1'b0;
    step("post_rst", col4(8'hd4, 8'hd4, 8'hd4, 8'hd5), 1'b1, 1'b0);
    check("post_rst_lit", out_col, col4(8'hd5, 8'hd5, 8'hd7, 8'hd6));

    // Random columns with random valid gaps (and random direction when
    // the inverse exists); forward results are fed back through inverse.
    for (int n = 0; n < 10000; n++) begin
      c = $urandom;
      v = ($urandom_range(0, 3) != 0);
`ifdef MIX_ONE_COLUMN_INV_EN
      iv = $urandom_range(0, 1) != 0;
`else
      iv = 1'b0;
`endif
      step("rnd", c, v, iv);
`ifdef MIX_ONE_COLUMN_INV_EN
      if (v && !iv) begin
        step("rt", exp_out, 1'b1, 1'b1);
        check("rt_orig", out_col, c);
      end
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
